// File: rtl/ysyx_25020037_lsu_pkg.sv
// Shared constants for the RV32E load/store unit: access size codes,
// AXI response codes, FSM state encoding and the default payload width.
package ysyx_25020037_lsu_pkg;

    // Default width of the opaque writeback/CSR payload.
    localparam int PASS_W_DFLT = 128;

    // Access size encodings carried on lw_lh_lb / sw_sh_sb.
    localparam logic [1:0] SZ_N = 2'b00;
    localparam logic [1:0] SZ_B = 2'b01;
    localparam logic [1:0] SZ_H = 2'b10;
    localparam logic [1:0] SZ_W = 2'b11;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR      = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // True when a half access is odd or a word access is not word aligned.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_25020037_lsu_align.sv
// Combinational byte-lane steering for the LSU: store strobe generation and
// data replication, plus load shift and sign/zero extension.
module ysyx_25020037_lsu_align
    import ysyx_25020037_lsu_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_st_size,
    input  logic [31:0] i_st_data,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    // Bring the addressed byte lane down to bit 0 of the read word.
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    // Store lanes: replicate the source so any strobed lane carries the data;
    // strobes shifted past bit 3 fall off the 4-bit field.
    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_st_data;
        case (i_st_size)
            SZ_B: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                o_wstrb = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_st_data;
            end
        endcase
    end

    // Load extension: lbu/lhu zero-fill, lb/lh replicate the top data bit.
    always_comb begin
        o_ld_data = w_shifted;
        case (i_ld_size)
            SZ_B: o_ld_data = i_ld_unsigned ? {24'h0, w_shifted[7:0]}
                                            : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_H: o_ld_data = i_ld_unsigned ? {16'h0, w_shifted[15:0]}
                                            : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: o_ld_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_25020037_lsu.sv
// Load/store unit between execute and writeback of the RV32E core.
// AXI4-Lite master with byte/half/word sizing and load extension.
// Optional: YSYX_25020037_LSU_MISALIGN_CHK_EN rejects misaligned half/word
// accesses with bus_err instead of issuing them on the bus.
module ysyx_25020037_lsu
    import ysyx_25020037_lsu_pkg::*;
#(
    parameter int PASS_W = PASS_W_DFLT,
    parameter int AW     = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_valid,
    output logic              lsu_ready,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [1:0]        lw_lh_lb,
    input  logic [1:0]        sw_sh_sb,
    input  logic              ld_unsigned,
    input  logic [AW-1:0]     mem_addr,
    input  logic [31:0]       st_data,
    input  logic [31:0]       alu_result,
    input  logic [PASS_W-1:0] pass_in,
    output logic [31:0]       rdata_processed,
    output logic              lsu_valid,
    input  logic              wbu_ready,
    output logic [31:0]       lsu_wb_data,
    output logic [PASS_W-1:0] pass_out,
    output logic              bus_err,
    output logic [AW-1:0]     araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [AW-1:0]     awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    logic [2:0]        r_state;
    logic              r_lsu_valid;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_bus_err;
    logic [31:0]       r_rdata_processed;
    logic [31:0]       r_wb_data;
    logic [PASS_W-1:0] r_pass_out;
    logic [AW-1:0]     r_addr;
    logic [31:0]       r_st_data;
    logic [1:0]        r_ld_size;
    logic [1:0]        r_st_size;
    logic              r_ld_unsigned;

    logic              w_accept;
    logic              w_misalign;
    logic              w_aw_done;
    logic              w_w_done;
    logic [31:0]       w_ld_data;

    // Accept only from IDLE, and only once the held result is being drained.
    assign lsu_ready = (r_state == ST_IDLE) && (!r_lsu_valid || wbu_ready);
    assign w_accept  = exu_valid && lsu_ready;

`ifdef YSYX_25020037_LSU_MISALIGN_CHK_EN
    // Misaligned half/word accesses never reach the bus.
    assign w_misalign = (mem_ren && is_misaligned(lw_lh_lb, mem_addr[1:0])) ||
                        (mem_wen && is_misaligned(sw_sh_sb, mem_addr[1:0]));
`else
    assign w_misalign = 1'b0;
`endif

    // A channel is finished once its valid has dropped or is handshaking now.
    assign w_aw_done = !r_awvalid || awready;
    assign w_w_done  = !r_wvalid  || wready;

    ysyx_25020037_lsu_align u_align (
        .i_addr_lo     (r_addr[1:0]),
        .i_st_size     (r_st_size),
        .i_st_data     (r_st_data),
        .i_ld_size     (r_ld_size),
        .i_ld_unsigned (r_ld_unsigned),
        .i_rdata       (rdata),
        .o_wstrb       (wstrb),
        .o_wdata       (wdata),
        .o_ld_data     (w_ld_data)
    );

    // Bus addresses are word aligned; byte selection is by strobe or shift.
    assign araddr          = {r_addr[AW-1:2], 2'b00};
    assign awaddr          = {r_addr[AW-1:2], 2'b00};
    assign arvalid         = r_arvalid;
    assign rready          = r_rready;
    assign awvalid         = r_awvalid;
    assign wvalid          = r_wvalid;
    assign bready          = r_bready;
    assign lsu_valid       = r_lsu_valid;
    assign bus_err         = r_bus_err;
    assign rdata_processed = r_rdata_processed;
    assign lsu_wb_data     = r_wb_data;
    assign pass_out        = r_pass_out;

    // Main sequencer: capture on accept, run the AXI handshakes, hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_lsu_valid       <= 1'b0;
            r_arvalid         <= 1'b0;
            r_rready          <= 1'b0;
            r_awvalid         <= 1'b0;
            r_wvalid          <= 1'b0;
            r_bready          <= 1'b0;
            r_bus_err         <= 1'b0;
            r_rdata_processed <= 32'h0;
            r_wb_data         <= 32'h0;
            r_pass_out        <= '0;
            r_addr            <= '0;
            r_st_data         <= 32'h0;
            r_ld_size         <= SZ_N;
            r_st_size         <= SZ_N;
            r_ld_unsigned     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr        <= mem_addr;
                        r_st_data     <= st_data;
                        r_ld_size     <= lw_lh_lb;
                        r_st_size     <= sw_sh_sb;
                        r_ld_unsigned <= ld_unsigned;
                        r_pass_out    <= pass_in;
                        r_lsu_valid   <= 1'b0;
                        r_bus_err     <= 1'b0;
                        if (w_misalign) begin
                            r_state     <= ST_DONE;
                            r_lsu_valid <= 1'b1;
                            r_bus_err   <= 1'b1;
                        end else if (mem_ren) begin
                            r_state   <= ST_RD_ADDR;
                            r_arvalid <= 1'b1;
                        end else if (mem_wen) begin
                            r_state   <= ST_WR;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            // Non-memory ops complete from IDLE in one cycle.
                            r_lsu_valid <= 1'b1;
                            r_wb_data   <= alu_result;
                        end
                    end else if (r_lsu_valid && wbu_ready) begin
                        r_lsu_valid <= 1'b0;
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        r_rready          <= 1'b0;
                        r_rdata_processed <= w_ld_data;
                        r_wb_data         <= w_ld_data;
                        r_bus_err         <= (rresp != RESP_OKAY);
                        r_lsu_valid       <= 1'b1;
                        r_state           <= ST_DONE;
                    end
                end
                ST_WR: begin
                    if (awready) r_awvalid <= 1'b0;
                    if (wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    // Stores leave lsu_wb_data untouched; rd is not written.
                    if (bvalid) begin
                        r_bready    <= 1'b0;
                        r_bus_err   <= (bresp != RESP_OKAY);
                        r_lsu_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (wbu_ready) begin
                        r_lsu_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
// Scoreboard bench for ysyx_25020037_lsu: stimulus pushes expected results and
// bus requests into queues; the slave model and result monitor pop and compare.
`timescale 1ns/1ps
module tb_ysyx_25020037_lsu;

    localparam int PW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          exu_valid, lsu_ready, mem_ren, mem_wen, ld_unsigned;
    logic [1:0]    lw_lh_lb, sw_sh_sb;
    logic [31:0]   mem_addr, st_data, alu_result;
    logic [PW-1:0] pass_in, pass_out;
    logic [31:0]   rdata_processed, lsu_wb_data;
    logic          lsu_valid, wbu_ready, bus_err;
    logic [31:0]   araddr, rdata, awaddr, wdata;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    rresp, bresp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]    wstrb;

    always #5 clk = ~clk;

    ysyx_25020037_lsu #(.PASS_W(PW), .AW(32)) dut (
        .clk(clk), .rst(rst), .exu_valid(exu_valid), .lsu_ready(lsu_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .lw_lh_lb(lw_lh_lb), .sw_sh_sb(sw_sh_sb),
        .ld_unsigned(ld_unsigned), .mem_addr(mem_addr), .st_data(st_data),
        .alu_result(alu_result), .pass_in(pass_in), .rdata_processed(rdata_processed),
        .lsu_valid(lsu_valid), .wbu_ready(wbu_ready), .lsu_wb_data(lsu_wb_data),
        .pass_out(pass_out), .bus_err(bus_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata),
        .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata),
        .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [31:0] wb;
        logic        chk_wb;
        logic        err;
        logic [31:0] pass;
        logic [31:0] rdp;
    } res_t;

    int checks = 0;
    int errors = 0;

    res_t        res_q[$];
    logic [31:0] ar_q[$];
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];

    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] s_rdata = 32'h0;
    logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
    int          ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout_or_unexpected expected=event", nm);
    endtask

    function automatic res_t mk(input logic [31:0] wb, input logic chk_wb, input logic err,
                                input logic [31:0] ps, input logic [31:0] rdp);
        res_t e;
        e.wb = wb; e.chk_wb = chk_wb; e.err = err; e.pass = ps; e.rdp = rdp;
        return e;
    endfunction

    // AXI slave model: readies/valids driven after each falling edge with programmable waits.
    initial begin
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        logic [35:0] we;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rdata = 0; rresp = 0; bresp = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if (arvalid) begin
                    arready = (ar_cnt >= ar_delay);
                    if (arready) begin
                        ar_hs++;
                        if (ar_q.size() == 0) fail("ar_unexpected");
                        else chk("araddr", araddr, ar_q.pop_front());
                    end
                    ar_cnt++;
                end else begin arready = 0; ar_cnt = 0; end
                if (rready) begin
                    rvalid = (r_cnt >= r_delay);
                    rdata  = s_rdata;
                    rresp  = s_rresp;
                    r_cnt++;
                end else begin rvalid = 0; r_cnt = 0; end
                if (awvalid) begin
                    awready = (aw_cnt >= aw_delay);
                    if (awready) begin
                        aw_hs++;
                        if (aw_q.size() == 0) fail("aw_unexpected");
                        else chk("awaddr", awaddr, aw_q.pop_front());
                    end
                    aw_cnt++;
                end else begin awready = 0; aw_cnt = 0; end
                if (wvalid) begin
                    wready = (w_cnt >= w_delay);
                    if (wready) begin
                        w_hs++;
                        if (w_q.size() == 0) fail("w_unexpected");
                        else begin
                            we = w_q.pop_front();
                            chk("wstrb", {28'h0, wstrb}, {28'h0, we[35:32]});
                            chk("wdata", wdata, we[31:0]);
                        end
                    end
                    w_cnt++;
                end else begin wready = 0; w_cnt = 0; end
                if (bready) begin
                    bvalid = (b_cnt >= b_delay);
                    bresp  = s_bresp;
                    if (bvalid) b_hs++;
                    b_cnt++;
                end else begin bvalid = 0; b_cnt = 0; end
            end
        end
    end

    // Result monitor: pops one expectation per writeback handshake.
    initial begin
        res_t e;
        forever begin
            @(negedge clk); #1;
            if (!rst && lsu_valid && wbu_ready) begin
                $display("RESULT wb=%h err=%b rdp=%h pass=%h", lsu_wb_data, bus_err,
                         rdata_processed, pass_out[31:0]);
                if (res_q.size() == 0) fail("result_unexpected");
                else begin
                    e = res_q.pop_front();
                    chk1("bus_err", bus_err, e.err);
                    if (e.chk_wb) chk("lsu_wb_data", lsu_wb_data, e.wb);
                    chk("rdata_processed", rdata_processed, e.rdp);
                    chk("pass_out_lo", pass_out[31:0], e.pass);
                    chk("pass_out_hi", pass_out[127:96], e.pass);
                end
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] alu,
                         input logic [31:0] ps, input res_t e);
        int n;
        @(negedge clk);
        exu_valid   = 1'b1;
        mem_ren     = rd;
        mem_wen     = wr;
        lw_lh_lb    = rd ? sz : 2'b00;
        sw_sh_sb    = wr ? sz : 2'b00;
        ld_unsigned = uns;
        mem_addr    = addr;
        st_data     = sd;
        alu_result  = alu;
        pass_in     = {4{ps}};
        #1;
        n = 0;
        while (!lsu_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!lsu_ready) fail("accept_timeout");
        res_q.push_back(e);
        @(posedge clk); #1;
        exu_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk); #1;
        while (!(res_q.size() == 0 && lsu_ready && !lsu_valid) && n < 500) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 500) fail("done_timeout");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, w0, b0, n;
        rst = 1; exu_valid = 0; mem_ren = 0; mem_wen = 0; lw_lh_lb = 0; sw_sh_sb = 0;
        ld_unsigned = 0; mem_addr = 0; st_data = 0; alu_result = 0; pass_in = '0; wbu_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_lsu_valid", lsu_valid, 1'b0);
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_wvalid", wvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_bready", bready, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk("rst_rdata_processed", rdata_processed, 32'h0);
        chk("rst_wb_data", lsu_wb_data, 32'h0);
        chk("rst_pass_out", pass_out[31:0], 32'h0);
        @(negedge clk); rst = 0; #1;
        chk1("ready_after_rst", lsu_ready, 1'b1);

        // Non-memory op: no bus traffic.
        a0 = ar_hs; w0 = aw_hs;
        issue(0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h1234_5678, 32'h0000_0001,
              mk(32'h1234_5678, 1, 0, 32'h0000_0001, 32'h0));
        wait_done();
        chk("nonmem_no_ar", ar_hs - a0, 0);
        chk("nonmem_no_aw", aw_hs - w0, 0);

        // Loads with lane shift and extension.
        s_rdata = 32'h80AA_BBCC;
        ar_q.push_back(32'h8000_0000);
        issue(1, 0, 2'b01, 0, 32'h8000_0003, 0, 0, 32'h0000_0002,
              mk(32'hFFFF_FF80, 1, 0, 32'h0000_0002, 32'hFFFF_FF80));
        wait_done();
        ar_q.push_back(32'h8000_0000);
        issue(1, 0, 2'b01, 1, 32'h8000_0003, 0, 0, 32'h0000_0003,
              mk(32'h0000_0080, 1, 0, 32'h0000_0003, 32'h0000_0080));
        wait_done();
        ar_q.push_back(32'h8000_0000);
        issue(1, 0, 2'b10, 0, 32'h8000_0002, 0, 0, 32'h0000_0004,
              mk(32'hFFFF_80AA, 1, 0, 32'h0000_0004, 32'hFFFF_80AA));
        wait_done();
        ar_q.push_back(32'h8000_0000);
        issue(1, 0, 2'b10, 1, 32'h8000_0002, 0, 0, 32'h0000_0005,
              mk(32'h0000_80AA, 1, 0, 32'h0000_0005, 32'h0000_80AA));
        wait_done();
        s_rdata = 32'hCAFE_F00D;
        ar_q.push_back(32'h8000_0004);
        issue(1, 0, 2'b11, 0, 32'h8000_0004, 0, 0, 32'h0000_0006,
              mk(32'hCAFE_F00D, 1, 0, 32'h0000_0006, 32'hCAFE_F00D));
        wait_done();

        // Stores: strobes and replication.
        aw_q.push_back(32'h8000_0000); w_q.push_back({4'b1100, 32'hBEEF_BEEF});
        issue(0, 1, 2'b10, 0, 32'h8000_0002, 32'hDEAD_BEEF, 0, 32'h0000_0007,
              mk(32'h0, 0, 0, 32'h0000_0007, 32'hCAFE_F00D));
        wait_done();
        aw_q.push_back(32'h8000_0000); w_q.push_back({4'b0010, 32'hA5A5_A5A5});
        issue(0, 1, 2'b01, 0, 32'h8000_0001, 32'h0000_00A5, 0, 32'h0000_0008,
              mk(32'h0, 0, 0, 32'h0000_0008, 32'hCAFE_F00D));
        wait_done();
        aw_q.push_back(32'h8000_0008); w_q.push_back({4'b1111, 32'h0123_4567});
        issue(0, 1, 2'b11, 0, 32'h8000_0008, 32'h0123_4567, 0, 32'h0000_0009,
              mk(32'h0, 0, 0, 32'h0000_0009, 32'hCAFE_F00D));
        wait_done();

        // Store with AW accepted three cycles before W.
        aw_delay = 0; w_delay = 3;
        a0 = aw_hs; w0 = w_hs; b0 = b_hs;
        aw_q.push_back(32'h8000_000C); w_q.push_back({4'b1111, 32'h5555_AAAA});
        issue(0, 1, 2'b11, 0, 32'h8000_000C, 32'h5555_AAAA, 0, 32'h0000_000A,
              mk(32'h0, 0, 0, 32'h0000_000A, 32'hCAFE_F00D));
        @(negedge clk); @(negedge clk); #1;
        chk1("split_awvalid_dropped", awvalid, 1'b0);
        chk1("split_wvalid_held", wvalid, 1'b1);
        wait_done();
        chk("split_aw_hs", aw_hs - a0, 1);
        chk("split_w_hs", w_hs - w0, 1);
        chk("split_b_hs", b_hs - b0, 1);
        w_delay = 0;

        // Back-to-back non-memory ops: second accepted while first drains.
        issue(0, 0, 2'b00, 0, 0, 0, 32'h1111_1111, 32'h0000_000B,
              mk(32'h1111_1111, 1, 0, 32'h0000_000B, 32'hCAFE_F00D));
        issue(0, 0, 2'b00, 0, 0, 0, 32'h2222_2222, 32'h0000_000C,
              mk(32'h2222_2222, 1, 0, 32'h0000_000C, 32'hCAFE_F00D));
        wait_done();

        // Store with error response.
        s_bresp = 2'b11;
        aw_q.push_back(32'h8000_0010); w_q.push_back({4'b0001, 32'h7777_7777});
        issue(0, 1, 2'b01, 0, 32'h8000_0010, 32'h0000_0077, 0, 32'h0000_000D,
              mk(32'h0, 0, 1, 32'h0000_000D, 32'hCAFE_F00D));
        wait_done();
        s_bresp = 2'b00;

        // Load error with writeback stalled four cycles.
        s_rdata = 32'h1122_3344; s_rresp = 2'b10;
        @(negedge clk); wbu_ready = 0;
        ar_q.push_back(32'h8000_0010);
        issue(1, 0, 2'b11, 0, 32'h8000_0010, 0, 0, 32'h0000_000E,
              mk(32'h1122_3344, 1, 1, 32'h0000_000E, 32'h1122_3344));
        n = 0;
        while (!lsu_valid && n < 100) begin @(negedge clk); #1; n++; end
        if (!lsu_valid) fail("err_load_valid_timeout");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk1("stall_lsu_valid", lsu_valid, 1'b1);
            chk1("stall_lsu_ready", lsu_ready, 1'b0);
            chk1("stall_bus_err", bus_err, 1'b1);
            chk("stall_wb_data", lsu_wb_data, 32'h1122_3344);
        end
        @(negedge clk); wbu_ready = 1;
        wait_done();
        s_rresp = 2'b00;

        // Reset while waiting for read data.
        r_delay = 6;
        ar_q.push_back(32'h8000_0020);
        issue(1, 0, 2'b11, 0, 32'h8000_0020, 0, 0, 32'h0000_000F,
              mk(32'h0, 1, 0, 32'h0000_000F, 32'h0));
        n = 0;
        @(negedge clk); #1;
        while (!rready && n < 100) begin @(negedge clk); #1; n++; end
        if (!rready) fail("rd_data_timeout");
        @(negedge clk); rst = 1; #1;
        chk1("midrst_rready", rready, 1'b0);
        chk1("midrst_arvalid", arvalid, 1'b0);
        chk1("midrst_lsu_valid", lsu_valid, 1'b0);
        chk1("midrst_awvalid", awvalid, 1'b0);
        chk("midrst_rdp", rdata_processed, 32'h0);
        res_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete();
        r_delay = 0;
        repeat (2) @(negedge clk);
        rst = 0; #1;
        chk1("midrst_ready_after", lsu_ready, 1'b1);
        s_rdata = 32'h0000_FE00;
        ar_q.push_back(32'h8000_0020);
        issue(1, 0, 2'b01, 0, 32'h8000_0021, 0, 0, 32'h0000_0010,
              mk(32'hFFFF_FFFE, 1, 0, 32'h0000_0010, 32'hFFFF_FFFE));
        wait_done();

        chk("ar_queue_drained", ar_q.size(), 0);
        chk("w_queue_drained", w_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
